// File: rtl/orao_io_pkg.sv
// Shared constants and helpers for the Orao I/O page and tape sample port.
package orao_io_pkg;

    localparam logic [4:0]  KBD_PAGE_DEF   = 5'b10000;
    localparam logic [4:0]  AUDIO_PAGE_DEF = 5'b10001;
    localparam logic [15:0] TAPE_ADDR_DEF  = 16'h87FF;
    localparam logic [7:0]  SAMPLE_ONE     = 8'hFF;
    localparam logic [7:0]  SAMPLE_ZERO    = 8'h00;

    // FIFO occupancy clipped to the five bits available in the status byte.
    function automatic logic [4:0] sat5(input int unsigned c);
        return (c > 32'd31) ? 5'd31 : c[4:0];
    endfunction

endpackage

// File: rtl/orao_tape_io_if.sv
// CPU bus, ioctl download and status signals of the Orao tape/I-O block.
interface orao_tape_io_if;
    logic        ce;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data_out;
    logic [7:0]  kbd_data;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        audio;
    logic        tape_active;
    logic        tape_overflow;

    modport master (
        output ce, addr, we, kbd_data, ioctl_download, ioctl_wr, ioctl_dout,
        input  data_out, ioctl_wait, audio, tape_active, tape_overflow
    );

    modport slave (
        input  ce, addr, we, kbd_data, ioctl_download, ioctl_wr, ioctl_dout,
        output data_out, ioctl_wait, audio, tape_active, tape_overflow
    );
endinterface

// File: rtl/orao_tape_io_fifo.sv
// 1-bit tape sample FIFO with occupancy outputs and a synchronous flush.
module tape_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic          din,
    output logic          dout,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          full,
    output logic          empty
);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign dout       = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/orao_tape_io.sv
// Orao I/O page decode: keyboard, buffered tape samples, audio flip-flop.
// Optional status byte at TAPE_ADDR-1 enabled by defining ORAO_TAPE_STATUS_EN.
module orao_tape_io
    import orao_io_pkg::*;
#(
    parameter int          DEPTH          = 16,
    parameter logic [7:0]  THRESH         = 8'h80,
    parameter int          READ_DIV       = 2,
    parameter int          TIMEOUT_CYCLES = 75000000,
    parameter logic [15:0] TAPE_ADDR      = TAPE_ADDR_DEF,
    parameter logic [4:0]  KBD_PAGE       = KBD_PAGE_DEF,
    parameter logic [4:0]  AUDIO_PAGE     = AUDIO_PAGE_DEF
) (
    input logic            clk,
    input logic            reset,
    orao_tape_io_if.slave  bus
);

    localparam int          CW          = $clog2(DEPTH) + 1;
    localparam int          DW          = (READ_DIV > 1) ? $clog2(READ_DIV) : 1;
    localparam int          TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] DEPTH_M1  = CW'(DEPTH - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(READ_DIV - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [15:0] STATUS_ADDR = TAPE_ADDR - 16'd1;

    logic [15:0]   addr_q;
    logic          dl_q;
    logic [DW-1:0] div_q, div_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          last_sample_q, last_sample_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          ioctl_wait_q, ioctl_wait_d;
    logic          audio_q, audio_d;
    logic          tape_active_q, tape_active_d;
    logic          tape_overflow_q, tape_overflow_d;

    logic          dl_rise, is_tape, read_ev, wr_req, push, drop;
    logic          div_wrap, clear_ev, tmo_sat, flush, pop;
    logic          head, full, empty;
    logic [CW-1:0] count, count_next;
    logic          unused_we;

    assign unused_we = bus.we;

    tape_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .pop        (pop),
        .din        (bus.ioctl_dout >= THRESH),
        .dout       (head),
        .count      (count),
        .count_next (count_next),
        .full       (full),
        .empty      (empty)
    );

    // Control decisions feeding the FIFO; kept apart from the register
    // next-state logic, which in turn depends on the FIFO's count_next.
    always_comb begin
        dl_rise  = bus.ioctl_download && !dl_q;
        is_tape  = (bus.addr == TAPE_ADDR);
        read_ev  = is_tape && (addr_q != TAPE_ADDR);
        wr_req   = bus.ioctl_download && bus.ioctl_wr;
        push     = wr_req && !full;
        drop     = wr_req && full;
        div_d    = div_q;
        div_wrap = 1'b0;
        if (read_ev) begin
            if (div_q == DIV_LAST) begin
                div_d    = '0;
                div_wrap = 1'b1;
            end else begin
                div_d = div_q + DW'(1);
            end
        end
        clear_ev = dl_rise || push || read_ev;
        tmo_sat  = (tmo_q == TMO_MAX);
        flush    = tmo_sat && !clear_ev;
        pop      = read_ev && div_wrap && !empty;
    end

    always_comb begin
        tmo_d           = clear_ev ? '0 : (tmo_sat ? tmo_q : tmo_q + TW'(1));
        last_sample_d   = pop ? head : last_sample_q;
        tape_overflow_d = (tape_overflow_q && !dl_rise) || drop;
        ioctl_wait_d    = (count_next >= DEPTH_M1) && bus.ioctl_download && (tmo_d != TMO_MAX);
        tape_active_d   = ((count_next != '0) || bus.ioctl_download) && (tmo_d != TMO_MAX);
        audio_d         = audio_q ^ (bus.ce && (bus.addr[15:11] == AUDIO_PAGE));
        data_out_d      = 8'hFF;
        if (is_tape) begin
            if (!empty) data_out_d = head ? SAMPLE_ONE : SAMPLE_ZERO;
            else        data_out_d = last_sample_q ? SAMPLE_ONE : SAMPLE_ZERO;
`ifdef ORAO_TAPE_STATUS_EN
        end else if (bus.addr == STATUS_ADDR) begin
            data_out_d = {tape_overflow_q, full, empty, sat5(32'(count))};
`endif
        end else if (bus.addr[15:11] == KBD_PAGE) begin
            data_out_d = bus.kbd_data;
        end
    end

    // A download already high at reset release must not look like a new edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q          <= '0;
            dl_q            <= bus.ioctl_download;
            div_q           <= '0;
            tmo_q           <= '0;
            last_sample_q   <= 1'b0;
            data_out_q      <= 8'hFF;
            ioctl_wait_q    <= 1'b0;
            audio_q         <= 1'b0;
            tape_active_q   <= 1'b0;
            tape_overflow_q <= 1'b0;
        end else begin
            addr_q          <= bus.addr;
            dl_q            <= bus.ioctl_download;
            div_q           <= div_d;
            tmo_q           <= tmo_d;
            last_sample_q   <= last_sample_d;
            data_out_q      <= data_out_d;
            ioctl_wait_q    <= ioctl_wait_d;
            audio_q         <= audio_d;
            tape_active_q   <= tape_active_d;
            tape_overflow_q <= tape_overflow_d;
        end
    end

    assign bus.data_out      = data_out_q;
    assign bus.ioctl_wait    = ioctl_wait_q;
    assign bus.audio         = audio_q;
    assign bus.tape_active   = tape_active_q;
    assign bus.tape_overflow = tape_overflow_q;

endmodule
